// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data-memory responder: access kinds, FSM states,
// legal frame masks and helpers that decode a mask into lane offset/width.
package data_memory_responder_pkg;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Mask bit3 is byte offset 0, bit0 is byte offset 3.
  localparam logic [3:0] MASK_B0 = 4'b1000;
  localparam logic [3:0] MASK_B1 = 4'b0100;
  localparam logic [3:0] MASK_B2 = 4'b0010;
  localparam logic [3:0] MASK_B3 = 4'b0001;
  localparam logic [3:0] MASK_H0 = 4'b1100;
  localparam logic [3:0] MASK_H1 = 4'b0011;
  localparam logic [3:0] MASK_W  = 4'b1111;

  function automatic logic mask_legal(input logic [3:0] m);
    case (m)
      MASK_B0, MASK_B1, MASK_B2, MASK_B3,
      MASK_H0, MASK_H1, MASK_W: mask_legal = 1'b1;
      default:                  mask_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] mask_offset(input logic [3:0] m);
    if (m[3])      mask_offset = 2'd0;
    else if (m[2]) mask_offset = 2'd1;
    else if (m[1]) mask_offset = 2'd2;
    else           mask_offset = 2'd3;
  endfunction

  // Bits of the right-justified data that carry selected bytes.
  function automatic logic [31:0] mask_keep(input logic [3:0] m);
    case (m)
      MASK_H0, MASK_H1: mask_keep = 32'h0000_FFFF;
      MASK_W:           mask_keep = 32'hFFFF_FFFF;
      default:          mask_keep = 32'h0000_00FF;
    endcase
  endfunction

  // RAM lane L (bits 8L+7:8L) is enabled by mask bit 3-L.
  function automatic logic [3:0] mask_lanes(input logic [3:0] m);
    mask_lanes = {m[0], m[1], m[2], m[3]};
  endfunction

endpackage

// File: rtl/data_memory_responder_byte_enable_ram.sv
// Word RAM with per-byte write enables and a registered read port; contents
// are deliberately not reset.
module byte_enable_ram #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [3:0]                     we,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem_r [DEPTH_WORDS];

  // Byte-lane writes and synchronous read of the addressed word
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (we[l]) begin
        mem_r[idx][8*l +: 8] <= wdata[8*l +: 8];
      end
    end
    rdata <= mem_r[idx];
  end

endmodule

// File: rtl/data_memory_responder.sv
// Memory-side responder: accepts one request, waits LATENCY cycles, performs a
// lane-shifted byte-enabled access and completes with a 4-phase handshake.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        enable,
  input  logic        memory_state,
  input  logic [3:0]  frame_mask,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        memory_done,
  output logic        busy,
  output logic        error
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t             state_r, state_next_s;
  logic [3:0]         cnt_r;
  logic               op_r;
  logic [3:0]         mask_r;
  logic [31:0]        addr_r, wdata_r;
  logic               access_s, ok_s, in_range_s;
  logic [1:0]         off_s;
  logic [IDX_W-1:0]   ram_idx_s;
  logic [3:0]         ram_we_s;
  logic [31:0]        ram_wdata_s, ram_rdata_s, rd_shift_s;

  // Next-state decode; access_s marks the edge that commits or captures data
  always_comb begin
    state_next_s = state_r;
    access_s     = 1'b0;
    case (state_r)
      IDLE:    if (enable) state_next_s = WAIT; else state_next_s = IDLE;
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_next_s = DONE;
          access_s     = 1'b1;
        end else begin
          state_next_s = WAIT;
        end
      end
      DONE:    state_next_s = RELEASE;
      RELEASE: if (!enable) state_next_s = IDLE; else state_next_s = RELEASE;
      default: state_next_s = IDLE;
    endcase
  end

  // Datapath: legality, lane placement and RAM controls
  always_comb begin
    in_range_s = ((addr_r >> (IDX_W + 2)) == 32'd0);
    ok_s       = mask_legal(mask_r) && in_range_s;
    off_s      = mask_offset(mask_r);
    // In IDLE the RAM already reads the incoming word so LATENCY=1 has data ready
    if (state_r == IDLE) ram_idx_s = address[IDX_W+1:2];
    else                 ram_idx_s = addr_r[IDX_W+1:2];
    ram_wdata_s = wdata_r << {off_s, 3'b000};
    rd_shift_s  = (ram_rdata_s >> {off_s, 3'b000}) & mask_keep(mask_r);
    if (access_s && ok_s && (op_r == MEM_WRITE)) ram_we_s = mask_lanes(mask_r);
    else                                          ram_we_s = 4'b0000;
  end

  byte_enable_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (CLK),
    .idx   (ram_idx_s),
    .we    (ram_we_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  // State, request latch, latency counter and registered outputs
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      op_r        <= MEM_READ;
      mask_r      <= 4'b0000;
      addr_r      <= 32'd0;
      wdata_r     <= 32'd0;
      read_data   <= 32'd0;
      memory_done <= 1'b0;
      busy        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      memory_done <= access_s;
      error       <= access_s && !ok_s;
      if (state_r == IDLE && enable) begin
        op_r    <= memory_state;
        mask_r  <= frame_mask;
        addr_r  <= address;
        wdata_r <= write_data;
        cnt_r   <= 4'(LATENCY - 1);
        busy    <= 1'b1;
      end else if (state_r == WAIT && cnt_r != 4'd0) begin
        cnt_r <= cnt_r - 4'd1;
      end else if (state_r == RELEASE && !enable) begin
        busy <= 1'b0;
      end
      if (access_s && ok_s && (op_r == MEM_READ)) begin
        read_data <= rd_shift_s;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed-vector bench with a scoreboard queue checked by a completion monitor.
module tb_data_memory_responder;

  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        memory_state = 1'b0;
  logic [3:0]  frame_mask = 4'b0000;
  logic [31:0] address = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_data;
  logic        memory_done, busy, error;

  data_memory_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .enable       (enable),
    .memory_state (memory_state),
    .frame_mask   (frame_mask),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .memory_done  (memory_done),
    .busy         (busy),
    .error        (error)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [31:0] last_rd = 32'd0;

  // Monitor: every completion pulse is compared with the oldest expectation
  always @(negedge CLK) begin
    if (!reset && memory_done) begin
      exp_t e;
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got memory_done=1, required no pending request");
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (read_data !== e.rd) begin
          errors++;
          $display("FAIL read_data: got %08h, required %08h", read_data, e.rd);
        end
        if (error !== e.err) begin
          errors++;
          $display("FAIL error_flag: got %0b, required %0b", error, e.err);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    while (busy === 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: got busy=%0b, required 0", busy);
    end
  endtask

  task automatic do_req(input logic op, input logic [3:0] m, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input int hold);
    exp_t e;
    int   n = 0;
    logic got = 1'b0;
    logic busy_ok = 1'b1;
    int   d0;
    wait_idle();
    if (op == 1'b0 && !exp_err) last_rd = exp_rd;
    e.rd  = last_rd;
    e.err = exp_err;
    exp_q.push_back(e);
    d0 = done_cnt;
    enable = 1'b1; memory_state = op; frame_mask = m; address = a; write_data = wd;
    @(posedge CLK);
    while (!got && n < 20) begin
      @(negedge CLK);
      n++;
      if (memory_done) got = 1'b1;
    end
    checks++;
    if (!got || n != LAT + 1) begin
      errors++;
      $display("FAIL latency: got done after %0d negedges (seen=%0b), required %0d", n, got, LAT + 1);
    end
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge CLK);
        if (busy !== 1'b1) busy_ok = 1'b0;
      end
      checks++;
      if (done_cnt - d0 != 1) begin
        errors++;
        $display("FAIL done_count: got %0d pulses, required 1", done_cnt - d0);
      end
      checks++;
      if (!busy_ok) begin
        errors++;
        $display("FAIL busy_hold: got busy low while enable held, required 1");
      end
    end
    enable = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    checks++;
    if (read_data !== 32'd0 || memory_done !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rd=%08h done=%0b busy=%0b err=%0b, required all 0",
               read_data, memory_done, busy, error);
    end
    reset = 1'b0;

    do_req(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    do_req(1'b0, 4'b1111, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    do_req(1'b1, 4'b0010, 32'h12, 32'h000000AA, 32'h0, 1'b0, 0);
    do_req(1'b0, 4'b1111, 32'h10, 32'h0, 32'hDEAABEEF, 1'b0, 0);
    do_req(1'b0, 4'b0010, 32'h10, 32'h0, 32'h000000AA, 1'b0, 0);
    do_req(1'b1, 4'b1111, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 0);
    do_req(1'b1, 4'b0011, 32'h20, 32'h00001234, 32'h0, 1'b0, 0);
    do_req(1'b0, 4'b0011, 32'h20, 32'h0, 32'h00001234, 1'b0, 0);
    do_req(1'b0, 4'b1100, 32'h20, 32'h0, 32'h0000F00D, 1'b0, 0);
    do_req(1'b0, 4'b1000, 32'h20, 32'h0, 32'h0000000D, 1'b0, 0);
    do_req(1'b0, 4'b0001, 32'h20, 32'h0, 32'h00000012, 1'b0, 0);
    // Illegal mask, out-of-range address and empty mask all flag error
    do_req(1'b1, 4'b1010, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
    do_req(1'b0, 4'b1111, 32'h10, 32'h0, 32'hDEAABEEF, 1'b0, 0);
    do_req(1'b0, 4'b1111, 32'h00001000, 32'h0, 32'h0, 1'b1, 0);
    do_req(1'b1, 4'b1111, 32'h00001010, 32'h55555555, 32'h0, 1'b1, 0);
    do_req(1'b0, 4'b0000, 32'h10, 32'h0, 32'h0, 1'b1, 0);
    do_req(1'b0, 4'b1111, 32'h10, 32'h0, 32'hDEAABEEF, 1'b0, 0);
    // Held enable: one pulse only, then immediate follow-on request
    do_req(1'b0, 4'b0100, 32'h10, 32'h0, 32'h000000BE, 1'b0, 10);
    do_req(1'b0, 4'b1111, 32'h20, 32'h0, 32'h1234F00D, 1'b0, 0);

    // Reset while a write sits in WAIT must abort it
    do_req(1'b1, 4'b1111, 32'h30, 32'h13579BDF, 32'h0, 1'b0, 0);
    wait_idle();
    enable = 1'b1; memory_state = 1'b1; frame_mask = 4'b1111;
    address = 32'h30; write_data = 32'hFFFFFFFF;
    @(posedge CLK);
    @(negedge CLK);
    reset = 1'b1;
    #1;
    checks++;
    if (read_data !== 32'd0 || memory_done !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got rd=%08h done=%0b busy=%0b err=%0b, required all 0",
               read_data, memory_done, busy, error);
    end
    last_rd = 32'd0;
    enable = 1'b0;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    do_req(1'b0, 4'b1111, 32'h30, 32'h0, 32'h13579BDF, 1'b0, 0);

    repeat (4) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending: got %0d outstanding expectations, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
